// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer: FSM encoding, decode width
// and the default identification word.
package apb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   localparam int unsigned APB_DECODE_BITS = 12;
   localparam logic [31:0] APB_DEFAULT_ID  = 32'hA9B0_0001;

endpackage

// File: rtl/apb_regbank.sv
// Register array behind the APB completer: one write port and a read mux,
// with slot 0 hardwired to the identification constant.
module apb_regbank
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned IDX_W    = $clog2(NUM_REGS),
   parameter logic [31:0] ID_VALUE = APB_DEFAULT_ID
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   // Slot 0 has no storage; it is a constant.
   logic [31:0] regs [1:NUM_REGS-1];

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_idx == '0) begin
         rd_data = ID_VALUE;
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
               rd_data = regs[i];
            end
         end
      end
   end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer with a programmable number of wait states, address/ID
// protection reported through pslverr, and a 32-bit register bank.
module apb_slave_regbank
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = APB_DEFAULT_ID
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] pr_data,
   output logic        pready,
   output logic        pslverr
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned SLOT_W = APB_DECODE_BITS - 2;
   localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(NUM_REGS);

   apb_state_e       state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             err_q, err_nxt;
   logic             wr_q, wr_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;

   logic [SLOT_W-1:0] slot;
   logic              setup_err;
   logic              wr_en;
   logic [31:0]       bank_rdata;
   logic              unused_paddr_hi;

   assign slot            = paddr[APB_DECODE_BITS-1:2];
   assign unused_paddr_hi = ^paddr[31:APB_DECODE_BITS];

   // Misaligned, beyond the bank, or an attempt to overwrite the ID slot.
   assign setup_err = (paddr[1:0] != 2'b00) | (slot >= SLOT_LIMIT)
                    | (pwrite & (slot == '0));

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= ST_IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
         wr_q  <= 1'b0;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err_q <= err_nxt;
         wr_q  <= wr_nxt;
         idx_q <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
      wr_nxt    = wr_q;
      idx_nxt   = idx_q;
      pready    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = 4'(WAIT_STATES);
               err_nxt   = setup_err;
               wr_nxt    = pwrite;
               idx_nxt   = paddr[IDX_W+1:2];
            end
         end
         ST_ACCESS: begin
            pready = (cnt == '0);
            if (!psel || pready) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // An aborted transfer (psel dropped) never commits a write.
   assign wr_en   = pready & psel & wr_q & ~err_q;
   assign pslverr = pready & err_q;
   assign pr_data = (pready & ~wr_q & ~err_q) ? bank_rdata : '0;

   apb_regbank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W),
      .ID_VALUE (ID_VALUE)
   ) u_regbank (
      .hclk    (hclk),
      .hresetn (hresetn),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (pwdata),
      .rd_idx  (idx_q),
      .rd_data (bank_rdata)
   );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed, table-driven bench for apb_slave_regbank: three instances with
// 0, 2 and 3 wait states share the bus and are selected individually.
module tb_apb_slave_regbank;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [2:0]  sel;
   logic [2:0]  rdy;
   logic [2:0]  err;
   logic [31:0] rd [3];

   int tests = 0;
   int fails = 0;

   always #5 hclk = ~hclk;

   apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(32'hA9B0_0001)) u_ws0 (
      .hclk(hclk), .hresetn(hresetn), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pr_data(rd[0]), .pready(rdy[0]), .pslverr(err[0]));

   apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(32'hA9B0_0001)) u_ws2 (
      .hclk(hclk), .hresetn(hresetn), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pr_data(rd[1]), .pready(rdy[1]), .pslverr(err[1]));

   apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(32'hA9B0_0001)) u_ws3 (
      .hclk(hclk), .hresetn(hresetn), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pr_data(rd[2]), .pready(rdy[2]), .pslverr(err[2]));

   typedef struct {
      int          k;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_waits;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after completion.
   task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output bit perr, output int waits);
      sel[k]  = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(posedge hclk);
      @(negedge hclk);
      penable = 1'b1;
      paddr   = 32'h0000_0FFF;
      pwrite  = ~wr;
      waits   = 0;
      rdata   = '0;
      perr    = 1'b0;
      while (!rdy[k] && waits <= 20) begin
         check($sformatf("inst%0d wait pr_data", k), rd[k], 32'h0);
         check($sformatf("inst%0d wait pslverr", k), {31'b0, err[k]}, 32'h0);
         @(posedge hclk);
         @(negedge hclk);
         waits++;
      end
      if (!rdy[k]) begin
         tests++;
         fails++;
         $display("FAIL inst%0d timeout: pready never rose within %0d cycles", k, waits);
      end
      rdata = rd[k];
      perr  = err[k];
      @(posedge hclk);
      @(negedge hclk);
      check($sformatf("inst%0d pready after completion", k), {31'b0, rdy[k]}, 32'h0);
      sel[k]  = 1'b0;
      penable = 1'b0;
   endtask

   task automatic xfer_chk(input string name, input int k, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit exp_err, input int exp_waits);
      logic [31:0] r;
      bit          e;
      int          w;
      xfer(k, wr, addr, wdata, r, e, w);
      check({name, " pr_data"}, r, exp_rd);
      check({name, " pslverr"}, {31'b0, e}, {31'b0, exp_err});
      check({name, " waits"}, 32'(w), 32'(exp_waits));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;

      vecs[0]  = '{1, 1'b1, 32'h004,  32'hDEAD_BEEF, 32'h0,          1'b0, 2};
      vecs[1]  = '{1, 1'b0, 32'h004,  32'h0,         32'hDEAD_BEEF,  1'b0, 2};
      vecs[2]  = '{1, 1'b0, 32'h000,  32'h0,         32'hA9B0_0001,  1'b0, 2};
      vecs[3]  = '{1, 1'b1, 32'h000,  32'h1234_5678, 32'h0,          1'b1, 2};
      vecs[4]  = '{1, 1'b0, 32'h000,  32'h0,         32'hA9B0_0001,  1'b0, 2};
      vecs[5]  = '{1, 1'b0, 32'h020,  32'h0,         32'h0,          1'b1, 2};
      vecs[6]  = '{1, 1'b1, 32'h005,  32'hCAFE_F00D, 32'h0,          1'b1, 2};
      vecs[7]  = '{1, 1'b0, 32'h004,  32'h0,         32'hDEAD_BEEF,  1'b0, 2};
      vecs[8]  = '{1, 1'b0, 32'h01C,  32'h0,         32'h0,          1'b0, 2};
      vecs[9]  = '{1, 1'b1, 32'h01C,  32'h0000_1234, 32'h0,          1'b0, 2};
      vecs[10] = '{1, 1'b0, 32'h01C,  32'h0,         32'h0000_1234,  1'b0, 2};
      vecs[11] = '{1, 1'b0, 32'h006,  32'h0,         32'h0,          1'b1, 2};
      vecs[12] = '{0, 1'b1, 32'h008,  32'h0000_0055, 32'h0,          1'b0, 0};
      vecs[13] = '{0, 1'b0, 32'h008,  32'h0,         32'h0000_0055,  1'b0, 0};
      vecs[14] = '{0, 1'b0, 32'h3FC,  32'h0,         32'h0,          1'b1, 0};
      vecs[15] = '{0, 1'b1, 32'h004,  32'h0000_0011, 32'h0,          1'b0, 0};
      vecs[16] = '{0, 1'b0, 32'h1004, 32'h0,         32'h0000_0011,  1'b0, 0};
      vecs[17] = '{2, 1'b0, 32'h00C,  32'h0,         32'h0,          1'b0, 3};

      hresetn = 1'b0;
      sel     = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (2) @(negedge hclk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset inst%0d pready", i), {31'b0, rdy[i]}, 32'h0);
         check($sformatf("reset inst%0d pslverr", i), {31'b0, err[i]}, 32'h0);
         check($sformatf("reset inst%0d pr_data", i), rd[i], 32'h0);
      end
      hresetn = 1'b1;
      @(negedge hclk);

      for (int i = 0; i < NV; i++) begin
         xfer_chk($sformatf("vec%0d", i), vecs[i].k, vecs[i].wr, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_waits);
      end

      // Abort: write setup then psel dropped after one access cycle.
      sel[2]  = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h00C;
      pwdata  = 32'hBADB_AD01;
      @(posedge hclk);
      @(negedge hclk);
      penable = 1'b1;
      check("abort first access pready", {31'b0, rdy[2]}, 32'h0);
      @(posedge hclk);
      @(negedge hclk);
      sel[2]  = 1'b0;
      penable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge hclk);
         @(negedge hclk);
         check($sformatf("abort idle cycle%0d pready", c), {31'b0, rdy[2]}, 32'h0);
      end
      xfer_chk("abort readback", 2, 1'b0, 32'h00C, 32'h0, 32'h0, 1'b0, 3);

      // penable without a setup phase must be ignored.
      sel[1]  = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 32'h004;
      for (int c = 0; c < 4; c++) begin
         @(posedge hclk);
         @(negedge hclk);
         check($sformatf("no-setup cycle%0d pready", c), {31'b0, rdy[1]}, 32'h0);
      end
      sel[1]  = 1'b0;
      penable = 1'b0;
      @(negedge hclk);
      xfer_chk("after no-setup read", 1, 1'b0, 32'h004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

      // Reset asserted during the completion cycle of a read.
      xfer_chk("pre-reset write", 2, 1'b1, 32'h010, 32'h0000_0077, 32'h0, 1'b0, 3);
      sel[2]  = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'h010;
      @(posedge hclk);
      @(negedge hclk);
      penable = 1'b1;
      waits   = 0;
      while (!rdy[2] && waits <= 20) begin
         @(posedge hclk);
         @(negedge hclk);
         waits++;
      end
      check("pre-reset read pr_data", rd[2], 32'h0000_0077);
      #2;
      hresetn = 1'b0;
      #1;
      check("async reset pready", {31'b0, rdy[2]}, 32'h0);
      check("async reset pslverr", {31'b0, err[2]}, 32'h0);
      check("async reset pr_data", rd[2], 32'h0);
      @(negedge hclk);
      sel     = '0;
      penable = 1'b0;
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      xfer_chk("post-reset inst2 0x010", 2, 1'b0, 32'h010, 32'h0, 32'h0, 1'b0, 3);
      xfer_chk("post-reset inst1 0x004", 1, 1'b0, 32'h004, 32'h0, 32'h0, 1'b0, 2);
      xfer_chk("post-reset inst0 0x008", 0, 1'b0, 32'h008, 32'h0, 32'h0, 1'b0, 0);
      xfer_chk("post-reset inst0 id",    0, 1'b0, 32'h000, 32'h0, 32'hA9B0_0001, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB completer (slave) at the far end of the AHB-to-APB bridge. It responds to one bit of the bridge's psel vector.
- Holds a bank of 32-bit registers and inserts a programmable number of wait states via pready.
- Flags illegal accesses with pslverr.
- Serves as the standard peripheral endpoint for the bridge and its bench, replacing the bench's random pr_data model.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 1, wait cycles inserted in every access phase; 0..15.
- ID_VALUE, 32'hA9B0_0001, read-only contents of register 0.

Ports:
- hclk  in  1  system clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- psel  in  1  select; one bit of the bridge's psel[2:0].
- penable  in  1  APB access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address; only paddr[11:0] is decoded.
- pwdata  in  32  write data.
- pr_data  out  32  read data.
- pready  out  1  transfer completes in this cycle when high.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset: asynchronous, active-low, on hresetn. State goes to IDLE, wait counter to 0, registers 1..NUM_REGS-1 to 0. Outputs: pr_data=0, pready=0, pslverr=0. Reset mid-transfer aborts the transfer with no register update.
- States: IDLE, ACCESS.
- IDLE: entered on a rising edge where psel=1 and penable=0 (setup phase). On that edge:
  - transition to ACCESS;
  - load counter with WAIT_STATES;
  - latch addr_err and wr_flag.
  - psel=1 with penable=1 seen while in IDLE is a protocol violation: ignore it, stay in IDLE, pready=0.
- ACCESS:
  - pready = (counter==0). Combinational from state and counter.
  - Each edge with counter!=0: decrement counter.
  - Edge with pready=1: return to IDLE.
  - If psel falls while in ACCESS: abort to IDLE on that edge, no write, no error.
- Back-to-back transfers: setup immediately after completion follows the normal IDLE path. Minimum transfer is 2 cycles (setup + access) with WAIT_STATES=0.
- Address decode: index = paddr[IDX_W+1:2], where IDX_W = clog2(NUM_REGS).
- addr_err is set on any of:
  - paddr[1:0] != 0;
  - paddr[11:2] >= NUM_REGS;
  - a write to index 0.
- Latching: addr_err, index and wr_flag are captured at the setup edge. paddr/pwrite changes during ACCESS are ignored.
- pslverr = pready & addr_err. It is 0 in all other cycles.
- Write: performed on the edge where state=ACCESS, pready=1, wr_flag=1 and addr_err=0. reg[index] <= pwdata sampled on that edge. Erroneous writes leave every register unchanged.
- Read: pr_data = reg[index] when state=ACCESS, pready=1, wr_flag=0 and addr_err=0. Otherwise pr_data=0, including erroneous reads and all wait cycles.
- Register 0 always reads ID_VALUE.
- Read-after-write to the same register in consecutive transfers returns the new value.
- Counter width is 4 bits; no wrap occurs because it is reloaded each setup.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding (ST_IDLE=1'b0, ST_ACCESS=1'b1);
  - APB_DECODE_BITS=12;
  - default ID constant.
- One natural sub-module: apb_regbank. It contains the register array, read mux, write port and register-0 constant.
- The FSM, wait counter and error decode stay in the top module.

Test Plan:
- Reset: hresetn low mid-ACCESS with WAIT_STATES=3 -> pready/pslverr/pr_data go to 0 immediately; registers read back 0 after release.
- Write with wait states: WAIT_STATES=2, write paddr=0x004, pwdata=0xDEADBEEF -> pready low for 2 access cycles, then high for 1 cycle with pslverr=0. Subsequent read of 0x004 returns 0xDEADBEEF with pr_data nonzero only in the pready cycle.
- ID register:
  - read 0x000 -> 0xA9B0_0001, pslverr=0;
  - write 0x000 with 0x12345678 -> pslverr=1 on the completion cycle;
  - re-read still returns 0xA9B0_0001.
- Decode errors with NUM_REGS=8:
  - read 0x020 -> pslverr=1, pr_data=0;
  - write 0x005 -> pslverr=1, no register changes;
  - read 0x01C -> pslverr=0.
- Back-to-back with WAIT_STATES=0: write 0x008=0x00000055 then immediately read 0x008 -> each transfer takes exactly 2 cycles; the read returns 0x00000055.
- Abort: setup a write to 0x00C (WAIT_STATES=3), drop psel after 1 access cycle -> FSM returns to IDLE; 0x00C still reads 0. A penable=1 pulse without a setup phase produces no pready.
